// File: rtl/io_input_conditioner_if.sv
// Wishbone slave bus for the input conditioner register window.
// Signal names keep the Caravel wbs_* naming so the harness can wire it
// straight through.
//   wbs_cyc_i/wbs_stb_i/wbs_we_i : cycle, strobe, write enable
//   wbs_sel_i                    : byte selects (writes need all four)
//   wbs_adr_i/wbs_dat_i          : address, write data
//   wbs_ack_o/wbs_dat_o          : single-cycle ack, registered read data
interface io_input_conditioner_if;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/io_input_conditioner.sv
// Input conditioner in front of the project-select harness.
// Every pad is synchronised into clk, optionally debounced per pin, and the
// registered result io_sync_out replaces raw io_in at the harness mux.
//
// Ports:
//   clk, reset_n : system clock, asynchronous active-low reset
//   io_in        : raw asynchronous pad inputs [WIDTH]
//   io_sync_out  : conditioned pad levels [WIDTH]
//   wb           : Wishbone slave (io_input_conditioner_if.slave)
//
// Register window (word offsets from BASE_ADDR):
//   0x00 DB_MASK0 RW   0x04 DB_MASK1 RW   0x08 DB_PERIOD RW (16b)
//   0x0C CHG0 W1C      0x10 CHG1 W1C      0x14 LEVEL0 RO  0x18 LEVEL1 RO
//
// Build option: define IO_COND_CHANGE_CAPTURE_EN to build the sticky
// per-pin change flags; without it CHG reads 0 and CHG writes are no-ops.
//
// The register map splits pins into a low word and a high word, so WIDTH
// must lie in 33..64.

// Per-pin slice: synchroniser chain, 3-sample history, debounced level.
module io_cond_pin #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic pin_i,
  input  logic tick_i,
  output logic s_o,
  output logic db_o
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic [2:0]             hist_q, hist_d;
  logic                   db_q;

  assign s_o    = sync_q[SYNC_STAGES-1];
  assign db_o   = db_q;
  // db follows the history it is about to store, so db and history move on
  // the same tick.
  assign hist_d = {hist_q[1:0], s_o};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      hist_q <= '0;
      db_q   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pin_i};
      if (tick_i) begin
        hist_q <= hist_d;
        if (&hist_d || ~|hist_d) db_q <= hist_d[0];
      end
    end
  end
endmodule

module io_input_conditioner #(
  parameter int          WIDTH         = 38,
  parameter int          SYNC_STAGES   = 2,
  parameter logic [31:0] BASE_ADDR     = 32'h3000_0600,
  parameter logic [15:0] DB_PERIOD_RST = 16'd40000
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [WIDTH-1:0]     io_in,
  output logic [WIDTH-1:0]     io_sync_out,
  io_input_conditioner_if.slave wb
);
  localparam int HI_W = WIDTH - 32;

  // ---------------- per-pin slices ----------------
  logic [WIDTH-1:0] s, db;
  logic             tick;

  io_cond_pin #(.SYNC_STAGES(SYNC_STAGES)) u_pin [WIDTH-1:0] (
    .clk    (clk),
    .reset_n(reset_n),
    .pin_i  (io_in),
    .tick_i (tick),
    .s_o    (s),
    .db_o   (db)
  );

  // ---------------- bus decode ----------------
  logic [31:0] off;
  logic [2:0]  widx;
  logic        hit, valid, wr;
  logic        ack_q;
  logic [31:0] dat_q, dat_d, rdata;

  assign off  = wb.wbs_adr_i - BASE_ADDR;   // wraps high for addresses below base
  assign widx = off[4:2];
  assign hit  = (off < 32'h1C) && (wb.wbs_adr_i[1:0] == 2'b00);
  // Blocking on ack_q guarantees a low cycle between acks even if the
  // master keeps strobing.
  assign valid = wb.wbs_cyc_i && wb.wbs_stb_i && hit && !ack_q;
  assign wr    = valid && wb.wbs_we_i && (&wb.wbs_sel_i);

  // ---------------- config registers ----------------
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [15:0]      period_q, period_d;
  logic [15:0]      cnt_q, cnt_d, cnt_last;

  always_comb begin
    mask_d   = mask_q;
    period_d = period_q;
    if (wr) begin
      case (widx)
        3'd0:    mask_d[31:0]      = wb.wbs_dat_i;
        3'd1:    mask_d[WIDTH-1:32] = wb.wbs_dat_i[HI_W-1:0];
        3'd2:    period_d          = wb.wbs_dat_i[15:0];
        default: ;
      endcase
    end
  end

  // ---------------- prescaler ----------------
  // Period 0 is treated as 1: tick every cycle.
  assign cnt_last = (period_q == 16'd0) ? 16'd0 : period_q - 16'd1;
  assign tick     = (cnt_q == cnt_last);

  always_comb begin
    if (wr && widx == 3'd2) cnt_d = 16'd0;
    else if (tick)          cnt_d = 16'd0;
    else                    cnt_d = cnt_q + 16'd1;
  end

  // ---------------- output mux ----------------
  logic [WIDTH-1:0] io_sync_q, io_sync_d;

  assign io_sync_d   = (mask_q & db) | (~mask_q & s);
  assign io_sync_out = io_sync_q;

  // ---------------- change capture ----------------
  logic [WIDTH-1:0] chg_rd;

`ifdef IO_COND_CHANGE_CAPTURE_EN
  logic [WIDTH-1:0] chg_q, chg_d, prev_q, clr;

  always_comb begin
    clr = '0;
    if (wr && widx == 3'd3) clr[31:0]       = wb.wbs_dat_i;
    if (wr && widx == 3'd4) clr[WIDTH-1:32] = wb.wbs_dat_i[HI_W-1:0];
    // OR-ing the edge after the clear makes a coincident set win.
    chg_d = (chg_q & ~clr) | (io_sync_q ^ prev_q);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      chg_q  <= '0;
      prev_q <= '0;
    end else begin
      chg_q  <= chg_d;
      prev_q <= io_sync_q;
    end
  end

  assign chg_rd = chg_q;
`else
  assign chg_rd = '0;
`endif

  // ---------------- read mux ----------------
  always_comb begin
    case (widx)
      3'd0:    rdata = mask_q[31:0];
      3'd1:    rdata = 32'(mask_q[WIDTH-1:32]);
      3'd2:    rdata = {16'h0000, period_q};
      3'd3:    rdata = chg_rd[31:0];
      3'd4:    rdata = 32'(chg_rd[WIDTH-1:32]);
      3'd5:    rdata = io_sync_q[31:0];
      3'd6:    rdata = 32'(io_sync_q[WIDTH-1:32]);
      default: rdata = 32'h0;
    endcase
  end

  // Data is only non-zero alongside an ack for a read.
  assign dat_d = (valid && !wb.wbs_we_i) ? rdata : 32'h0;

  assign wb.wbs_ack_o = ack_q;
  assign wb.wbs_dat_o = dat_q;

  // ---------------- state ----------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask_q    <= '0;
      period_q  <= DB_PERIOD_RST;
      cnt_q     <= 16'd0;
      io_sync_q <= '0;
      ack_q     <= 1'b0;
      dat_q     <= 32'h0;
    end else begin
      mask_q    <= mask_d;
      period_q  <= period_d;
      cnt_q     <= cnt_d;
      io_sync_q <= io_sync_d;
      ack_q     <= valid;
      dat_q     <= dat_d;
    end
  end
endmodule
